jb_ul_dfe_cfg_commit: RTL and testbench

//   Parametrised UL DFE control register bank: software writes a shadow copy of carrier NCO, stream gain,

---
 rtl/jb_ul_dfe_cfg_commit.sv | 268 ++++++++++++++++++++++++++
 tb/tb_jb_ul_dfe_cfg_commit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jb_ul_dfe_cfg_commit.sv
`default_nettype none
// ============================================================================
// Module   : jb_ul_dfe_cfg_commit
// Brief    : UL DFE shadow/active control bank; armed commits land on frame sync.
//            Optional macro JB_UL_DFE_CFG_IMMEDIATE_EN adds commit_imm_i.
// Revision : 1.0
// ============================================================================
module jb_ul_dfe_cfg_commit #(
  parameter int NUM_CAR     = 2,
  parameter int NUM_ANT     = 4,
  parameter int TIMEOUT_CYC = 0,
  parameter int TO_W        = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en_i,
  input  logic [7:0]                    wr_addr_i,
  input  logic [31:0]                   wr_data_i,
  input  logic                          rd_en_i,
  input  logic [7:0]                    rd_addr_i,
  output logic [31:0]                   rd_data_o,
  input  logic                          commit_req_i,
`ifdef JB_UL_DFE_CFG_IMMEDIATE_EN
  input  logic                          commit_imm_i,
`endif
  input  logic                          sync_pulse_i,
  output logic                          busy_o,
  output logic                          commit_done_o,
  output logic                          timeout_err_o,
  output logic                          ul_ant_int_frac_delay_trig_o,
  output logic [NUM_CAR*32-1:0]         ul_car_nco_lsb_o,
  output logic [NUM_CAR*8-1:0]          ul_car_nco_msb_o,
  output logic [NUM_CAR-1:0]            ul_car_nco_sign_o,
  output logic [NUM_CAR*NUM_ANT-1:0]    ul_stream_gain_scaler_sign_o,
  output logic [NUM_CAR*NUM_ANT*4-1:0]  ul_stream_gain_scaler_o,
  output logic [NUM_CAR*NUM_ANT*16-1:0] ul_stream_gain_fraction_o,
  output logic [NUM_ANT-1:0]            ul_ant_gain_scaler_sign_o,
  output logic [NUM_ANT*4-1:0]          ul_ant_gain_scaler_o,
  output logic [NUM_ANT*16-1:0]         ul_ant_gain_fraction_o,
  output logic [NUM_CAR*NUM_ANT*7-1:0]  ul_int_delay_o,
  output logic [NUM_CAR*NUM_ANT*16-1:0] ul_frac_delay_o
);

  localparam int            c_nca     = NUM_CAR * NUM_ANT;
  localparam logic          c_to_en   = (TIMEOUT_CYC > 0);
  localparam logic [TO_W-1:0] c_to_last = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              terr_q, terr_d;
  logic              done_q, apply_d;
  logic [31:0]       rd_data_q, rd_word;
  logic              imm;

  logic [NUM_CAR*32-1:0] sh_lsb_q, ac_lsb_q;
  logic [NUM_CAR*8-1:0]  sh_msb_q, ac_msb_q;
  logic [NUM_CAR-1:0]    sh_nsg_q, ac_nsg_q;
  logic [c_nca-1:0]      sh_sgs_q, ac_sgs_q;
  logic [c_nca*4-1:0]    sh_sgm_q, ac_sgm_q;
  logic [c_nca*16-1:0]   sh_sgf_q, ac_sgf_q;
  logic [NUM_ANT-1:0]    sh_ags_q, ac_ags_q;
  logic [NUM_ANT*4-1:0]  sh_agm_q, ac_agm_q;
  logic [NUM_ANT*16-1:0] sh_agf_q, ac_agf_q;
  logic [c_nca*7-1:0]    sh_dint_q, ac_dint_q;
  logic [c_nca*16-1:0]   sh_dfr_q, ac_dfr_q;

  // Address legality: NCO uses addr[4:1] as carrier with addr[5] unused;
  // antenna gain leaves addr[5:3] unused.
  function automatic logic addr_ok(input logic [7:0] a);
    logic car_nco, car_ok, ant_ok;
    car_nco = 32'(a[4:1]) < 32'(NUM_CAR);
    car_ok  = 32'(a[5:3]) < 32'(NUM_CAR);
    ant_ok  = 32'(a[2:0]) < 32'(NUM_ANT);
    case (a[7:6])
      2'b00:   return !a[5] && car_nco;
      2'b10:   return (a[5:3] == 3'd0) && ant_ok;
      default: return car_ok && ant_ok;
    endcase
  endfunction

  function automatic int car_of(input logic [7:0] a);
    return (a[7:6] == 2'b00) ? 32'(a[4:1]) : 32'(a[5:3]);
  endfunction

  logic wr_ok, rd_ok;
  int   wr_car, wr_ant, wr_idx, rd_car, rd_ant, rd_idx;

  assign wr_ok  = wr_en_i && addr_ok(wr_addr_i);
  assign wr_car = car_of(wr_addr_i);
  assign wr_ant = 32'(wr_addr_i[2:0]);
  assign wr_idx = wr_car * NUM_ANT + wr_ant;
  assign rd_ok  = addr_ok(rd_addr_i);
  assign rd_car = car_of(rd_addr_i);
  assign rd_ant = 32'(rd_addr_i[2:0]);
  assign rd_idx = rd_car * NUM_ANT + rd_ant;

`ifdef JB_UL_DFE_CFG_IMMEDIATE_EN
  assign imm = commit_imm_i;
`else
  assign imm = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      terr_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      terr_q    <= terr_d;
      done_q    <= apply_d;
      rd_data_q <= rd_en_i ? rd_word : 32'd0;
    end
  end

  // Sync beats a coincident timeout; requests while armed are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    apply_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit_req_i) begin
          terr_d = 1'b0;
          cnt_d  = '0;
          if (imm) apply_d = 1'b1;
          else     state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (sync_pulse_i) begin
          apply_d = 1'b1;
          state_d = ST_IDLE;
        end else if (c_to_en && (cnt_q == c_to_last)) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (c_to_en) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_lsb_q  <= '0;
      sh_msb_q  <= '0;
      sh_nsg_q  <= '0;
      sh_sgs_q  <= '0;
      sh_sgm_q  <= '0;
      sh_sgf_q  <= '0;
      sh_ags_q  <= '0;
      sh_agm_q  <= '0;
      sh_agf_q  <= '0;
      sh_dint_q <= '0;
      sh_dfr_q  <= '0;
    end else if (wr_ok) begin
      for (int c = 0; c < NUM_CAR; c++) begin
        if (wr_addr_i[7:6] == 2'b00 && wr_car == c) begin
          if (wr_addr_i[0]) begin
            sh_msb_q[c*8 +: 8] <= wr_data_i[7:0];
            sh_nsg_q[c]        <= wr_data_i[8];
          end else begin
            sh_lsb_q[c*32 +: 32] <= wr_data_i;
          end
        end
      end
      for (int i = 0; i < c_nca; i++) begin
        if (wr_addr_i[7:6] == 2'b01 && wr_idx == i) begin
          sh_sgs_q[i]         <= wr_data_i[20];
          sh_sgm_q[i*4 +: 4]  <= wr_data_i[19:16];
          sh_sgf_q[i*16 +: 16] <= wr_data_i[15:0];
        end
        if (wr_addr_i[7:6] == 2'b11 && wr_idx == i) begin
          sh_dint_q[i*7 +: 7]  <= wr_data_i[22:16];
          sh_dfr_q[i*16 +: 16] <= wr_data_i[15:0];
        end
      end
      for (int a = 0; a < NUM_ANT; a++) begin
        if (wr_addr_i[7:6] == 2'b10 && wr_ant == a) begin
          sh_ags_q[a]          <= wr_data_i[20];
          sh_agm_q[a*4 +: 4]   <= wr_data_i[19:16];
          sh_agf_q[a*16 +: 16] <= wr_data_i[15:0];
        end
      end
    end
  end

  // Non-blocking copy means a write in the apply cycle stays in shadow only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac_lsb_q  <= '0;
      ac_msb_q  <= '0;
      ac_nsg_q  <= '0;
      ac_sgs_q  <= '0;
      ac_sgm_q  <= '0;
      ac_sgf_q  <= '0;
      ac_ags_q  <= '0;
      ac_agm_q  <= '0;
      ac_agf_q  <= '0;
      ac_dint_q <= '0;
      ac_dfr_q  <= '0;
    end else if (apply_d) begin
      ac_lsb_q  <= sh_lsb_q;
      ac_msb_q  <= sh_msb_q;
      ac_nsg_q  <= sh_nsg_q;
      ac_sgs_q  <= sh_sgs_q;
      ac_sgm_q  <= sh_sgm_q;
      ac_sgf_q  <= sh_sgf_q;
      ac_ags_q  <= sh_ags_q;
      ac_agm_q  <= sh_agm_q;
      ac_agf_q  <= sh_agf_q;
      ac_dint_q <= sh_dint_q;
      ac_dfr_q  <= sh_dfr_q;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      for (int c = 0; c < NUM_CAR; c++) begin
        if (rd_addr_i[7:6] == 2'b00 && rd_car == c) begin
          rd_word = rd_addr_i[0] ? {23'd0, sh_nsg_q[c], sh_msb_q[c*8 +: 8]}
                                 : sh_lsb_q[c*32 +: 32];
        end
      end
      for (int i = 0; i < c_nca; i++) begin
        if (rd_addr_i[7:6] == 2'b01 && rd_idx == i)
          rd_word = {11'd0, sh_sgs_q[i], sh_sgm_q[i*4 +: 4], sh_sgf_q[i*16 +: 16]};
        if (rd_addr_i[7:6] == 2'b11 && rd_idx == i)
          rd_word = {9'd0, sh_dint_q[i*7 +: 7], sh_dfr_q[i*16 +: 16]};
      end
      for (int a = 0; a < NUM_ANT; a++) begin
        if (rd_addr_i[7:6] == 2'b10 && rd_ant == a)
          rd_word = {11'd0, sh_ags_q[a], sh_agm_q[a*4 +: 4], sh_agf_q[a*16 +: 16]};
      end
    end
  end

  assign rd_data_o                    = rd_data_q;
  assign busy_o                       = (state_q == ST_ARMED);
  assign commit_done_o                = done_q;
  assign ul_ant_int_frac_delay_trig_o = done_q;
  assign timeout_err_o                = terr_q;
  assign ul_car_nco_lsb_o             = ac_lsb_q;
  assign ul_car_nco_msb_o             = ac_msb_q;
  assign ul_car_nco_sign_o            = ac_nsg_q;
  assign ul_stream_gain_scaler_sign_o = ac_sgs_q;
  assign ul_stream_gain_scaler_o      = ac_sgm_q;
  assign ul_stream_gain_fraction_o    = ac_sgf_q;
  assign ul_ant_gain_scaler_sign_o    = ac_ags_q;
  assign ul_ant_gain_scaler_o         = ac_agm_q;
  assign ul_ant_gain_fraction_o       = ac_agf_q;
  assign ul_int_delay_o               = ac_dint_q;
  assign ul_frac_delay_o              = ac_dfr_q;

endmodule
`default_nettype wire

// File: tb/tb_jb_ul_dfe_cfg_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_jb_ul_dfe_cfg_commit
// Brief    : Address-image reference model of the config bank, per-cycle compare.
// Revision : 1.0
// ============================================================================
module tb_jb_ul_dfe_cfg_commit;
  localparam int NC = 2;
  localparam int NA = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0, rd_en = 1'b0, commit_req = 1'b0, sync = 1'b0, commit_imm = 1'b0;
  logic [7:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic busy, commit_done, timeout_err, trig;
  logic [NC*32-1:0]    nco_lsb;
  logic [NC*8-1:0]     nco_msb;
  logic [NC-1:0]       nco_sign;
  logic [NC*NA-1:0]    sg_sign;
  logic [NC*NA*4-1:0]  sg_scl;
  logic [NC*NA*16-1:0] sg_frac;
  logic [NA-1:0]       ag_sign;
  logic [NA*4-1:0]     ag_scl;
  logic [NA*16-1:0]    ag_frac;
  logic [NC*NA*7-1:0]  d_int;
  logic [NC*NA*16-1:0] d_frac;

  int checks = 0;
  int errors = 0;

  jb_ul_dfe_cfg_commit #(.NUM_CAR(NC), .NUM_ANT(NA), .TIMEOUT_CYC(TO), .TO_W(24)) dut (
    .clk(clk), .rst(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .commit_req_i(commit_req),
`ifdef JB_UL_DFE_CFG_IMMEDIATE_EN
    .commit_imm_i(commit_imm),
`endif
    .sync_pulse_i(sync), .busy_o(busy), .commit_done_o(commit_done),
    .timeout_err_o(timeout_err), .ul_ant_int_frac_delay_trig_o(trig),
    .ul_car_nco_lsb_o(nco_lsb), .ul_car_nco_msb_o(nco_msb), .ul_car_nco_sign_o(nco_sign),
    .ul_stream_gain_scaler_sign_o(sg_sign), .ul_stream_gain_scaler_o(sg_scl),
    .ul_stream_gain_fraction_o(sg_frac), .ul_ant_gain_scaler_sign_o(ag_sign),
    .ul_ant_gain_scaler_o(ag_scl), .ul_ant_gain_fraction_o(ag_frac),
    .ul_int_delay_o(d_int), .ul_frac_delay_o(d_frac)
  );

  always #5 clk = ~clk;

  // Reference model: shadow/active are images of the readable address space.
  logic [31:0] m_sh  [0:255];
  logic [31:0] m_act [0:255];
  logic        m_armed, m_done, m_terr, m_rd_vld;
  logic [31:0] m_rd;
  int          m_age;

  function automatic logic [31:0] fmask(input logic [7:0] a);
    int car, ant;
    car = 32'(a[5:3]);
    ant = 32'(a[2:0]);
    case (a[7:6])
      2'b00: begin
        car = 32'(a[4:1]);
        if (a[5] || car >= NC) return 32'd0;
        return a[0] ? 32'h0000_01FF : 32'hFFFF_FFFF;
      end
      2'b01:   return (car < NC && ant < NA) ? 32'h001F_FFFF : 32'd0;
      2'b10:   return (a[5:3] == 3'd0 && ant < NA) ? 32'h001F_FFFF : 32'd0;
      default: return (car < NC && ant < NA) ? 32'h007F_FFFF : 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        m_sh[i]  <= '0;
        m_act[i] <= '0;
      end
      m_armed <= 1'b0; m_done <= 1'b0; m_terr <= 1'b0;
      m_rd <= '0; m_rd_vld <= 1'b0; m_age <= 0;
    end else begin
      m_done   <= 1'b0;
      m_rd_vld <= rd_en;
      m_rd     <= m_sh[rd_addr];
      if (wr_en) m_sh[wr_addr] <= wr_data & fmask(wr_addr);
      if (!m_armed) begin
        if (commit_req) begin
          m_terr <= 1'b0;
          m_age  <= 0;
          if (commit_imm) begin
            m_done <= 1'b1;
            for (int i = 0; i < 256; i++) m_act[i] <= m_sh[i];
          end else begin
            m_armed <= 1'b1;
          end
        end
      end else if (sync) begin
        m_done  <= 1'b1;
        m_armed <= 1'b0;
        for (int i = 0; i < 256; i++) m_act[i] <= m_sh[i];
      end else if (m_age + 1 == TO) begin
        m_armed <= 1'b0;
        m_terr  <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  function automatic logic [255:0] exp_bus(input int which);
    logic [255:0] r;
    logic [31:0]  w;
    int           i;
    r = '0;
    for (int c = 0; c < NC; c++) begin
      w = m_act[2*c];
      if (which == 0) r[c*32 +: 32] = w;
      w = m_act[2*c+1];
      if (which == 1) r[c*8 +: 8] = w[7:0];
      if (which == 2) r[c] = w[8];
      for (int a = 0; a < NA; a++) begin
        i = c*NA + a;
        w = m_act[64 + 8*c + a];
        if (which == 3) r[i] = w[20];
        if (which == 4) r[i*4 +: 4] = w[19:16];
        if (which == 5) r[i*16 +: 16] = w[15:0];
        w = m_act[192 + 8*c + a];
        if (which == 9)  r[i*7 +: 7] = w[22:16];
        if (which == 10) r[i*16 +: 16] = w[15:0];
      end
    end
    for (int a = 0; a < NA; a++) begin
      w = m_act[128 + a];
      if (which == 6) r[a] = w[20];
      if (which == 7) r[a*4 +: 4] = w[19:16];
      if (which == 8) r[a*16 +: 16] = w[15:0];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 256'(busy), 256'(m_armed));
    chk("commit_done", 256'(commit_done), 256'(m_done));
    chk("trig", 256'(trig), 256'(m_done));
    chk("timeout_err", 256'(timeout_err), 256'(m_terr));
    if (m_rd_vld) chk("rd_data", 256'(rd_data), 256'(m_rd));
    chk("nco_lsb", 256'(nco_lsb), exp_bus(0));
    chk("nco_msb", 256'(nco_msb), exp_bus(1));
    chk("nco_sign", 256'(nco_sign), exp_bus(2));
    chk("sg_sign", 256'(sg_sign), exp_bus(3));
    chk("sg_scl", 256'(sg_scl), exp_bus(4));
    chk("sg_frac", 256'(sg_frac), exp_bus(5));
    chk("ag_sign", 256'(ag_sign), exp_bus(6));
    chk("ag_scl", 256'(ag_scl), exp_bus(7));
    chk("ag_frac", 256'(ag_frac), exp_bus(8));
    chk("d_int", 256'(d_int), exp_bus(9));
    chk("d_frac", 256'(d_frac), exp_bus(10));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    d = rd_data;
  endtask

  task automatic pulse_req();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  logic [7:0]  wa [9] = '{8'h00, 8'h01, 8'h45, 8'h4B, 8'h83, 8'hD9, 8'hCA, 8'h06, 8'h20};
  logic [31:0] wd [9] = '{32'hDEADBEEF, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF,
                          32'h00A51234, 32'h00011111, 32'h007FFFFF, 32'h55555555, 32'h66666666};

  initial begin
    logic [31:0] d, acc;
    int n, bcnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", 256'(busy), 256'd0);
    chk("reset_lsb", 256'(nco_lsb), 256'd0);

    acc = '0;
    for (int a = 0; a < 256; a++) begin
      rd(8'(a), d);
      acc = acc | d;
    end
    chk("reset_rd_all", 256'(acc), 256'd0);

    for (int i = 0; i < 9; i++) wr(wa[i], wd[i]);
    rd(8'h4B, d); chk("rd_sg_c1a3", 256'(d), 256'h001F_FFFF);
    rd(8'h45, d); chk("rd_sg_ant5", 256'(d), 256'd0);
    rd(8'h01, d); chk("rd_msb_c0", 256'(d), 256'h1FF);
    rd(8'h83, d); chk("rd_ag_a3", 256'(d), 256'h0005_1234);

    wr(8'h02, 32'h12345678);
    wr(8'h03, 32'h000001A5);
    pulse_req();
    bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) bcnt++;
      if (i == 9) sync = 1'b1;
      tick();
    end
    sync = 1'b0;
    chk("busy_cycles", 256'(bcnt), 256'd10);
    chk("nco_lsb1", 256'(nco_lsb[63:32]), 256'h12345678);
    chk("nco_msb1", 256'(nco_msb[15:8]), 256'hA5);
    chk("nco_sign1", 256'(nco_sign[1]), 256'd1);
    chk("done_pulse", 256'({commit_done, trig, busy}), 256'b110);
    tick();
    chk("done_clear", 256'({commit_done, trig}), 256'd0);

    pulse_req();
    n = 0;
    while (!timeout_err && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 256'(n), 256'd16);
    chk("timeout_busy", 256'(busy), 256'd0);
    chk("timeout_keep", 256'(nco_lsb[63:32]), 256'h12345678);
    pulse_req();
    chk("terr_cleared", 256'({timeout_err, busy}), 256'b01);

    wr_en = 1'b1; wr_addr = 8'hC3; wr_data = 32'h00050100; sync = 1'b1;
    tick();
    wr_en = 1'b0; sync = 1'b0;
    chk("wr_at_sync_int", 256'(d_int[27:21]), 256'd0);
    rd(8'hC3, d); chk("wr_at_sync_rd", 256'(d), 256'h0005_0100);
    pulse_req();
    pulse_sync();
    chk("delay_int3", 256'(d_int[27:21]), 256'd5);
    chk("delay_frac3", 256'(d_frac[63:48]), 256'h0100);

    pulse_req();
    repeat (15) tick();
    pulse_sync();
    chk("sync_vs_timeout", 256'({commit_done, timeout_err}), 256'b10);

    commit_req = 1'b1; sync = 1'b1;
    tick();
    commit_req = 1'b0; sync = 1'b0;
    chk("req_sync_idle", 256'({busy, commit_done}), 256'b10);
    pulse_sync();
    chk("req_sync_apply", 256'(commit_done), 256'd1);

    wr(8'h4F, 32'hFFFFFFFF);
    rd(8'h4F, d); chk("rd_4F", 256'(d), 256'd0);
    wr(8'hA1, 32'hFFFFFFFF);
    rd(8'hA1, d); chk("rd_A1", 256'(d), 256'd0);

    wr(8'h00, 32'h0BADF00D);
    pulse_req();
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("rst_armed", 256'({busy, commit_done, trig}), 256'd0);
    chk("rst_active", 256'(nco_lsb), 256'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    pulse_sync();
    chk("rst_no_commit", 256'({busy, commit_done, trig}), 256'd0);

`ifdef JB_UL_DFE_CFG_IMMEDIATE_EN
    wr(8'h81, 32'h00138000);
    commit_imm = 1'b1;
    pulse_req();
    commit_imm = 1'b0;
    chk("imm_sign", 256'(ag_sign[1]), 256'd1);
    chk("imm_scl", 256'(ag_scl[7:4]), 256'd3);
    chk("imm_frac", 256'(ag_frac[31:16]), 256'h8000);
    chk("imm_trig", 256'({trig, busy}), 256'b10);
`endif

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
